// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall sequencer for IF stage and IF/ID register: load-use, MDU and imem-wait stalls.
// Optional STALL_CNT_EN macro builds the 32-bit stall-cycle counter; otherwise stall_cycles is 0.
module pipe_stall_ctrl #(
  parameter int unsigned MDU_LAT   = 32,
  parameter int unsigned CNT_W     = 6,
  parameter int unsigned FETCH_TMO = 64,
  parameter int unsigned TMO_W     = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic        i_rs,
  input  logic        i_rt,
  input  logic [4:0]  ern,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        mdu_start,
  input  logic        imem_ready,
  output logic        wpcir,
  output logic        bubble,
  output logic        mdu_busy,
  output logic        fetch_err,
  output logic [31:0] stall_cycles
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] MDU   = 2'd1;
  localparam logic [1:0] FETCH = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [TMO_W-1:0] fcnt, fcnt_nxt;
  logic             lu, in_mdu, go;

  assign lu = ewreg & em2reg & (ern != 5'd0) &
              ((i_rs & (ern == rs)) | (i_rt & (ern == rt)));
  assign in_mdu = (state == MDU);

  // RUN, FETCH and the illegal encoding share the same advance condition
  assign go       = ~in_mdu & imem_ready & ~lu;
  assign wpcir    = resetn & go;
  assign bubble   = ~wpcir;
  assign mdu_busy = resetn & in_mdu;

  always_comb begin
    state_nxt = RUN;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (go & mdu_start) begin
          state_nxt = MDU;
          cnt_nxt   = CNT_W'(MDU_LAT - 1);
        end else if (~imem_ready & ~lu) begin
          state_nxt = FETCH;
        end
      end
      MDU: begin
        if (cnt != '0) begin
          state_nxt = MDU;
          cnt_nxt   = cnt - CNT_W'(1);
        end
      end
      FETCH:   state_nxt = imem_ready ? RUN : FETCH;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    fcnt_nxt = fcnt;
    if (!in_mdu) begin
      if (imem_ready)
        fcnt_nxt = '0;
      else if (fcnt != TMO_W'(FETCH_TMO))
        fcnt_nxt = fcnt + TMO_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= RUN;
      cnt       <= '0;
      fcnt      <= '0;
      fetch_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      fcnt      <= fcnt_nxt;
      fetch_err <= fetch_err | (fcnt_nxt == TMO_W'(FETCH_TMO));
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] scnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      scnt <= '0;
    else if (!wpcir)
      scnt <= scnt + 32'd1;
  end

  assign stall_cycles = scnt;
`else
  assign stall_cycles = '0;
`endif

endmodule
